// File: rtl/divide_unit.sv
// Multi-cycle signed restoring divider: one quotient bit per clock, sign fix-up,
// then a single-cycle done pulse. Quotient/remainder truncate toward zero.
//
// state | meaning
// IDLE  | waiting for start; operands sampled here only
// CALC  | restoring shift/subtract, one quotient bit per cycle
// FIX   | apply quotient/remainder signs, load result registers
// DONE  | results valid, done pulse, return to IDLE
module divide_unit #(
  parameter int WL = 32,
  parameter int CW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [WL-1:0] a,
  input  logic [WL-1:0] b,
  output logic [WL-1:0] Quot,
  output logic [WL-1:0] Rem,
  output logic          DivZero,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [WL-1:0] dvd;
  logic [WL:0]   dvs;
  logic [WL:0]   prem;
  logic [CW-1:0] cnt;
  logic          sq;
  logic          sr;

  logic          b_zero;
  logic [WL-1:0] mag_a;
  logic [WL:0]   mag_b;
  logic [WL+1:0] trial;
  logic [WL+1:0] diff;
  logic          borrow;

  assign b_zero = (b == '0);

  // Unsigned magnitudes, so the most negative operand maps to 2^(WL-1) exactly.
  assign mag_a = a[WL-1] ? (~a + 1'b1) : a;
  assign mag_b = b[WL-1] ? -{b[WL-1], b} : {1'b0, b};

  assign trial  = {prem, dvd[WL-1]};
  assign diff   = trial - {1'b0, dvs};
  assign borrow = diff[WL+1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = b_zero ? DONE : CALC;
        end
      end
      CALC: begin
        if (cnt == '0) begin
          state_nxt = FIX;
        end
      end
      FIX:     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      Quot    <= '0;
      Rem     <= '0;
      DivZero <= 1'b0;
      dvd     <= '0;
      dvs     <= '0;
      prem    <= '0;
      cnt     <= '0;
      sq      <= 1'b0;
      sr      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (b_zero) begin
              Quot    <= '1;
              Rem     <= a;
              DivZero <= 1'b1;
            end else begin
              dvd  <= mag_a;
              dvs  <= mag_b;
              sq   <= a[WL-1] ^ b[WL-1];
              sr   <= a[WL-1];
              prem <= '0;
              cnt  <= CW'(WL - 1);
            end
          end
        end
        CALC: begin
          // A borrow means the trial subtraction went negative: restore.
          if (borrow) begin
            prem <= trial[WL:0];
            dvd  <= {dvd[WL-2:0], 1'b0};
          end else begin
            prem <= diff[WL:0];
            dvd  <= {dvd[WL-2:0], 1'b1};
          end
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end
        end
        FIX: begin
          Quot    <= sq ? (~dvd + 1'b1) : dvd;
          Rem     <= sr ? (~prem[WL-1:0] + 1'b1) : prem[WL-1:0];
          DivZero <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divide_unit.sv
// Directed bench for divide_unit: sign cases, divide by zero, MIN/-1,
// ignored start while busy and reset in the middle of an operation.
module tb_divide_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] Quot;
  logic [31:0] Rem;
  logic        DivZero;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;

  divide_unit #(.WL(32), .CW(6)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .Quot    (Quot),
    .Rem     (Rem),
    .DivZero (DivZero),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one division and wait (bounded) for done; cycle 1 is the cycle after the accepting edge.
  task automatic run_div(input string tag, input logic [31:0] ta, input logic [31:0] tb_,
                         input logic [31:0] eq, input logic [31:0] er, input logic edz,
                         input int elat);
    int cyc;
    int busy_low;
    a = ta;
    b = tb_;
    start = 1'b1;
    step();
    start = 1'b0;
    a = 32'hDEAD_BEEF;
    b = 32'h0;
    cyc = 1;
    busy_low = 0;
    while (!done && cyc < 100) begin
      if (!busy) busy_low++;
      step();
      cyc++;
    end
    chk({tag, " latency"}, 32'(cyc), 32'(elat));
    chk({tag, " quot"}, Quot, eq);
    chk({tag, " rem"}, Rem, er);
    chk({tag, " divzero"}, {31'b0, DivZero}, {31'b0, edz});
    chk({tag, " busy_during"}, 32'(busy_low), 32'd0);
    chk({tag, " busy_at_done"}, {31'b0, busy}, 32'd1);
    step();
    chk({tag, " done_pulse"}, {31'b0, done}, 32'd0);
    chk({tag, " busy_after"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    int cyc;
    int ndone;
    int done_cyc;
    logic [31:0] q_at;
    logic [31:0] r_at;

    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    step();
    step();
    rst = 1'b0;
    chk("reset quot", Quot, 32'd0);
    chk("reset rem", Rem, 32'd0);
    chk("reset divzero", {31'b0, DivZero}, 32'd0);
    chk("reset busy", {31'b0, busy}, 32'd0);
    chk("reset done", {31'b0, done}, 32'd0);

    run_div("pos 100/7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 34);
    run_div("neg -100/7", 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 34);
    run_div("neg 100/-7", 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2, 1'b0, 34);
    run_div("neg -100/-7", 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 32'hFFFF_FFFE, 1'b0, 34);
    run_div("div0 5/0", 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 1);
    run_div("after div0 9/3", 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 34);
    run_div("min/-1", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 34);
    run_div("min/1", 32'h8000_0000, 32'd1, 32'h8000_0000, 32'd0, 1'b0, 34);
    run_div("small 3/10", 32'd3, 32'd10, 32'd0, 32'd3, 1'b0, 34);

    // start pulsed while busy must be ignored
    a = 32'd100;
    b = 32'd7;
    start = 1'b1;
    step();
    start = 1'b0;
    cyc = 1;
    ndone = 0;
    done_cyc = 0;
    q_at = '0;
    r_at = '0;
    while (cyc < 80) begin
      if (cyc == 4) begin
        a = 32'd1;
        b = 32'd1;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        ndone++;
        if (ndone == 1) begin
          done_cyc = cyc;
          q_at = Quot;
          r_at = Rem;
        end
      end
      step();
      cyc++;
    end
    chk("ignored start ndone", 32'(ndone), 32'd1);
    chk("ignored start latency", 32'(done_cyc), 32'd34);
    chk("ignored start quot", q_at, 32'd14);
    chk("ignored start rem", r_at, 32'd2);

    // reset in the middle of CALC discards the operation
    a = 32'd1000;
    b = 32'd3;
    start = 1'b1;
    step();
    start = 1'b0;
    cyc = 1;
    while (cyc < 10) begin
      step();
      cyc++;
    end
    chk("midrst busy before", {31'b0, busy}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst busy", {31'b0, busy}, 32'd0);
    chk("midrst done", {31'b0, done}, 32'd0);
    chk("midrst quot", Quot, 32'd0);
    chk("midrst rem", Rem, 32'd0);
    ndone = 0;
    for (int i = 0; i < 50; i++) begin
      if (done) ndone++;
      step();
    end
    chk("midrst no done", 32'(ndone), 32'd0);
    run_div("after rst 9/2", 32'd9, 32'd2, 32'd4, 32'd1, 1'b0, 34);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
